// File: rtl/pwm_signal_gen_pkg.sv
// Shared types and constants for the PWM signal generator.
// The DONE state exists only when PWM_GEN_BURST_EN is defined.
package pwm_signal_gen_pkg;

    localparam int DEF_CNT_W  = 24;
    localparam int MIN_PERIOD = 2;
    localparam int BURST_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
`ifdef PWM_GEN_BURST_EN
        ,
        DONE = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Period wrap counter with registered level and period-start outputs.
// Period is the config of the current cycle; High is the config of the next one.
module pwm_period_counter
    import pwm_signal_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Run,
    input  logic             RunNext,
    input  logic [CNT_W-1:0] Period,
    input  logic [CNT_W-1:0] High,
    output logic [CNT_W-1:0] Cnt,
    output logic             Wrap,
    output logic             Level,
    output logic             First
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             first_q, first_d;

    assign Wrap = Run && (cnt_q >= Period - CNT_W'(1));

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = '0;
        if (RunNext && Run && !Wrap) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Outputs are registered from the next count so they line up with Cnt.
        level_d = RunNext && (cnt_d < High);
        first_d = RunNext && (cnt_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            first_q <= first_d;
        end
    end

    assign Cnt   = cnt_q;
    assign Level = level_q;
    assign First = first_q;

endmodule

// File: rtl/pwm_signal_gen.sv
// PWM generator: run FSM, config handshake with shadow register, glitch-free switching.
// Define PWM_GEN_BURST_EN to add the CfgBurst/Done burst mode and DONE state.
module pwm_signal_gen
    import pwm_signal_gen_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = 100000,
    parameter int DEF_HIGH   = 50000
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic               CfgValid,
    output logic               CfgReady,
    input  logic [CNT_W-1:0]   CfgPeriod,
    input  logic [CNT_W-1:0]   CfgHigh,
    output logic               CfgErr,
    output logic               SignalOut,
    output logic               PeriodStart
`ifdef PWM_GEN_BURST_EN
    ,
    input  logic [BURST_W-1:0] CfgBurst,
    output logic               Done
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] shd_period_q, shd_period_d;
    logic [CNT_W-1:0] shd_high_q, shd_high_d;
    logic             pending_q, pending_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_offer, cfg_accept, cfg_apply;
    logic             wrap;
    logic [CNT_W-1:0] cnt;

`ifdef PWM_GEN_BURST_EN
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] shd_burst_q, shd_burst_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               done_q, done_d;
    logic               burst_last;

    assign burst_last = (burst_q != '0) && (burst_cnt_q == burst_q - BURST_W'(1));
`endif

    always_comb begin
        cfg_offer  = CfgValid && !pending_q;
        cfg_accept = cfg_offer && (CfgPeriod >= CNT_W'(MIN_PERIOD));
        cfg_err_d  = cfg_offer && !cfg_accept;
        // Outside RUN a config takes effect at once; inside RUN only at a wrap.
        cfg_apply  = ((state_q != RUN) || wrap) && (cfg_accept || pending_q);

        period_d     = period_q;
        high_d       = high_q;
        shd_period_d = shd_period_q;
        shd_high_d   = shd_high_q;
        pending_d    = pending_q;
`ifdef PWM_GEN_BURST_EN
        burst_d      = burst_q;
        shd_burst_d  = shd_burst_q;
`endif

        if (cfg_apply) begin
            period_d  = cfg_accept ? CfgPeriod : shd_period_q;
            high_d    = cfg_accept ? CfgHigh   : shd_high_q;
            pending_d = 1'b0;
`ifdef PWM_GEN_BURST_EN
            burst_d   = cfg_accept ? CfgBurst  : shd_burst_q;
`endif
        end else if (cfg_accept) begin
            shd_period_d = CfgPeriod;
            shd_high_d   = CfgHigh;
            pending_d    = 1'b1;
`ifdef PWM_GEN_BURST_EN
            shd_burst_d  = CfgBurst;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (En) state_d = RUN;
            RUN: begin
                if (!En) begin
                    state_d = IDLE;
`ifdef PWM_GEN_BURST_EN
                end else if (wrap && burst_last) begin
                    state_d = DONE;
`endif
                end
            end
`ifdef PWM_GEN_BURST_EN
            DONE: begin
                if (!En) begin
                    state_d = IDLE;
                end else if (cfg_accept) begin
                    state_d = RUN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef PWM_GEN_BURST_EN
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if ((state_d != RUN) || (state_q != RUN) || cfg_apply) begin
            burst_cnt_d = '0;
        end else if (wrap) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
        done_d = (state_d == DONE);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            period_q     <= CNT_W'(DEF_PERIOD);
            high_q       <= CNT_W'(DEF_HIGH);
            shd_period_q <= '0;
            shd_high_q   <= '0;
            pending_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
`ifdef PWM_GEN_BURST_EN
            burst_q      <= '0;
            shd_burst_q  <= '0;
            burst_cnt_q  <= '0;
            done_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            high_q       <= high_d;
            shd_period_q <= shd_period_d;
            shd_high_q   <= shd_high_d;
            pending_q    <= pending_d;
            cfg_err_q    <= cfg_err_d;
`ifdef PWM_GEN_BURST_EN
            burst_q      <= burst_d;
            shd_burst_q  <= shd_burst_d;
            burst_cnt_q  <= burst_cnt_d;
            done_q       <= done_d;
`endif
        end
    end

    pwm_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .Clk     (Clk),
        .Rst     (Rst),
        .Run     (state_q == RUN),
        .RunNext (state_d == RUN),
        .Period  (period_q),
        .High    (high_d),
        .Cnt     (cnt),
        .Wrap    (wrap),
        .Level   (SignalOut),
        .First   (PeriodStart)
    );

    // The period only changes at a wrap, so the count must stay inside it.
    always_ff @(posedge Clk) begin
        if (!Rst && (state_q == RUN)) begin
            assert (cnt <= period_q - CNT_W'(1));
        end
    end

    assign CfgReady = !pending_q;
    assign CfgErr   = cfg_err_q;
`ifdef PWM_GEN_BURST_EN
    assign Done     = done_q;
`endif

endmodule
